sram_confreg_resp: RTL and testbench

- Responder (slave) end of the data-SRAM interface driven by the CPU core.
- Decodes the confreg I/O window: LEDs, seven-segment number, switches, free-running timer, eight scratch registers and a simulation flag.
- Fixed 1-cycle read latency and per-byte write enables, the same timing as the data SRAM it sits beside.
- Upstream address-range selection decides which accesses reach this block; only addr[15:0] is decoded here.

---
 rtl/sram_confreg_resp.sv | 192 +++++++++++++++++++
 tb/tb_sram_confreg_resp.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_confreg_resp.sv
// Confreg I/O responder on the data-SRAM port: 1-cycle registered reads, byte-enable writes,
// LED/number/switch/timer/scratch registers and a multiplexed seven-segment scan.
module sram_confreg_resp #(
    parameter logic        SIMULATION = 1'b0,
    parameter int unsigned SCAN_DIV   = 10000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [15:0] led,
    output logic [1:0]  led_rg0,
    output logic [1:0]  led_rg1,
    output logic [7:0]  num_csn,
    output logic [6:0]  num_a_g,
    input  logic [7:0]  switch
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    localparam logic [15:0] A_TIMER   = 16'hE000;
    localparam logic [15:0] A_LED     = 16'hF000;
    localparam logic [15:0] A_LED_RG0 = 16'hF004;
    localparam logic [15:0] A_LED_RG1 = 16'hF008;
    localparam logic [15:0] A_NUM     = 16'hF010;
    localparam logic [15:0] A_SWITCH  = 16'hF020;
    localparam logic [15:0] A_SIMU    = 16'hF030;
    localparam logic [15:0] A_IO_SIMU = 16'hFFF0;

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    logic [31:0] cr_q [8];
    logic [31:0] cr_d [8];
    logic [31:0] timer_q, timer_d;
    logic [15:0] led_q, led_d;
    logic [1:0]  rg0_q, rg0_d;
    logic [1:0]  rg1_q, rg1_d;
    logic [31:0] num_q, num_d;
    logic [31:0] simu_q, simu_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  sw_meta_q, sw_sync_q;
    logic [15:0] div_q, div_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  csn_q, csn_d;
    logic [6:0]  seg_q, seg_d;

    logic [15:0] a16;
    logic        sel_cr;
    logic [2:0]  cr_idx;
    logic        do_wr, do_rd;
    logic [31:0] reg_val;
    logic [31:0] wr_merged;
    logic        unused_addr_bits;

    assign a16              = {addr[15:2], 2'b00};
    assign sel_cr           = (a16[15:5] == 11'h400);
    assign cr_idx           = a16[4:2];
    assign do_wr            = en & (|wen);
    assign do_rd            = en & ~(|wen);
    assign unused_addr_bits = ^{addr[31:16], addr[1:0]};

    // Current (zero-extended) value of the addressed register; also the base for byte merging.
    always_comb begin
        reg_val = '0;
        if (sel_cr) begin
            reg_val = cr_q[cr_idx];
        end else begin
            case (a16)
                A_TIMER:   reg_val = timer_q;
                A_LED:     reg_val = {16'h0, led_q};
                A_LED_RG0: reg_val = {30'h0, rg0_q};
                A_LED_RG1: reg_val = {30'h0, rg1_q};
                A_NUM:     reg_val = num_q;
                A_SWITCH:  reg_val = {24'h0, sw_sync_q};
                A_SIMU:    reg_val = {31'h0, SIMULATION};
                A_IO_SIMU: reg_val = simu_q;
                default:   reg_val = '0;
            endcase
        end
    end

    always_comb begin
        wr_merged = reg_val;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) wr_merged[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    always_comb begin
        cr_d    = cr_q;
        timer_d = timer_q + 32'd1;
        led_d   = led_q;
        rg0_d   = rg0_q;
        rg1_d   = rg1_q;
        num_d   = num_q;
        simu_d  = simu_q;
        rdata_d = do_rd ? reg_val : rdata_q;
        if (do_wr) begin
            if (sel_cr) begin
                cr_d[cr_idx] = wr_merged;
            end else begin
                case (a16)
                    A_TIMER:   timer_d = wr_merged;
                    A_LED:     led_d   = wr_merged[15:0];
                    A_LED_RG0: rg0_d   = wr_merged[1:0];
                    A_LED_RG1: rg1_d   = wr_merged[1:0];
                    A_NUM:     num_d   = wr_merged;
                    A_IO_SIMU: simu_d  = {wr_merged[15:0], wr_merged[31:16]};
                    default:   ;
                endcase
            end
        end
    end

    // Segments are re-decoded every cycle so a NUM change shows on the next edge.
    always_comb begin
        div_d = div_q + 16'd1;
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 3'd1;
        end
        csn_d = ~(8'd1 << idx_d);
        seg_d = hex_seg(num_q[{idx_d, 2'b00} +: 4]);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) cr_q[i] <= '0;
            timer_q   <= '0;
            led_q     <= '0;
            rg0_q     <= '0;
            rg1_q     <= '0;
            num_q     <= '0;
            simu_q    <= '0;
            rdata_q   <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            div_q     <= '0;
            idx_q     <= '0;
            csn_q     <= 8'hFE;
            seg_q     <= 7'h7E;
        end else begin
            cr_q      <= cr_d;
            timer_q   <= timer_d;
            led_q     <= led_d;
            rg0_q     <= rg0_d;
            rg1_q     <= rg1_d;
            num_q     <= num_d;
            simu_q    <= simu_d;
            rdata_q   <= rdata_d;
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
            div_q     <= div_d;
            idx_q     <= idx_d;
            csn_q     <= csn_d;
            seg_q     <= seg_d;
        end
    end

    assign rdata   = rdata_q;
    assign led     = led_q;
    assign led_rg0 = rg0_q;
    assign led_rg1 = rg1_q;
    assign num_csn = csn_q;
    assign num_a_g = seg_q;

endmodule

// File: tb/tb_sram_confreg_resp.sv
// Bench for sram_confreg_resp: directed vector table, seven-segment scan sequence,
// then random traffic checked against an address-keyed register model.
module tb_sram_confreg_resp;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] led;
    logic [1:0]  led_rg0, led_rg1;
    logic [7:0]  num_csn;
    logic [6:0]  num_a_g;
    logic [7:0]  switch;

    int checks = 0;
    int errors = 0;

    sram_confreg_resp #(.SIMULATION(1'b1), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .resetn(resetn), .en(en), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata), .led(led), .led_rg0(led_rg0), .led_rg1(led_rg1),
        .num_csn(num_csn), .num_a_g(num_a_g), .switch(switch)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  sw;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vq[$];

    logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    logic [15:0] pool [18] = '{16'h8000, 16'h8004, 16'h8008, 16'h800C, 16'h8010, 16'h8014,
                               16'h8018, 16'h801C, 16'hE000, 16'hF000, 16'hF004, 16'hF008,
                               16'hF010, 16'hF020, 16'hF030, 16'hFFF0, 16'hF100, 16'h1234};

    // Reference model: register contents keyed by decoded address.
    logic [31:0] m_reg [int];
    logic [31:0] m_timer;
    logic [7:0]  m_s1, m_s2;
    int          m_edges;
    logic [31:0] exp_rd;
    logic [7:0]  exp_csn;
    logic [6:0]  exp_seg;
    bit          model_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic add_vec(input logic e, input logic [3:0] w, input logic [31:0] a,
                           input logic [31:0] d, input logic [7:0] s, input logic [31:0] x);
        vec_t v;
        v.en = e; v.wen = w; v.addr = a; v.wdata = d; v.sw = s; v.exp_rd = x;
        vq.push_back(v);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] width_mask(input logic [15:0] a);
        if (a == 16'hF000) return 32'h0000FFFF;
        if (a == 16'hF004 || a == 16'hF008) return 32'h00000003;
        return 32'hFFFFFFFF;
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        if (a == 16'hE000) return m_timer;
        if (a == 16'hF020) return {24'h0, m_s2};
        if (a == 16'hF030) return 32'h1;
        if (m_reg.exists(int'(a))) return m_reg[int'(a)];
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_reg.delete();
        for (int k = 0; k < 8; k++) m_reg[32'h8000 + 4*k] = 32'h0;
        m_reg[32'hF000] = 0; m_reg[32'hF004] = 0; m_reg[32'hF008] = 0;
        m_reg[32'hF010] = 0; m_reg[32'hFFF0] = 0;
        m_timer = 0; m_s1 = 0; m_s2 = 0; m_edges = 0;
        exp_rd = 0; exp_csn = 8'hFE; exp_seg = 7'h7E;
    endtask

    task automatic model_edge();
        logic [15:0] a = {addr[15:2], 2'b00};
        logic [31:0] old_num = m_reg[32'hF010];
        logic [31:0] v;
        bit timer_wr = 1'b0;
        int idx;
        if (en && wen == 4'b0000) exp_rd = model_read(a);
        if (en && wen != 4'b0000) begin
            if (a == 16'hE000) begin
                m_timer = merge(m_timer, wdata, wen);
                timer_wr = 1'b1;
            end else if (m_reg.exists(int'(a))) begin
                v = merge(m_reg[int'(a)], wdata, wen) & width_mask(a);
                if (a == 16'hFFF0) v = {v[15:0], v[31:16]};
                m_reg[int'(a)] = v;
            end
        end
        if (!timer_wr) m_timer = m_timer + 1;
        m_s2 = m_s1;
        m_s1 = switch;
        m_edges++;
        idx = (m_edges / SCAN_DIV) % 8;
        exp_csn = ~(8'd1 << idx);
        exp_seg = seg_tab[(old_num >> (4*idx)) & 32'hF];
    endtask

    task automatic tick();
        @(posedge clk);
        if (model_on) model_edge();
        #1;
        if (model_on) begin
            chk("rnd_rdata", rdata, exp_rd);
            chk("rnd_led", {16'h0, led}, m_reg[32'hF000]);
            chk("rnd_rg0", {30'h0, led_rg0}, m_reg[32'hF004]);
            chk("rnd_rg1", {30'h0, led_rg1}, m_reg[32'hF008]);
            chk("rnd_csn", {24'h0, num_csn}, {24'h0, exp_csn});
            chk("rnd_seg", {25'h0, num_a_g}, {25'h0, exp_seg});
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_csn", {24'h0, num_csn}, 32'hFE);
        chk("rst_seg", {25'h0, num_a_g}, 32'h7E);
        chk("rst_led", {12'h0, led, led_rg0, led_rg1}, 32'h0);
        #2;
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] d);
        en = e; wen = w; addr = a; wdata = d;
    endtask

    initial begin
        logic [7:0] prev;
        bit found;
        resetn = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        switch = 8'h00;
        #12;
        do_reset();

        // Directed vectors: exp_rd is rdata after the edge.
        add_vec(1, 4'h0, 32'h0000F030, 32'h0, 8'h00, 32'h00000001);
        add_vec(1, 4'hF, 32'h00008004, 32'hAABBCCDD, 8'h00, 32'h00000001);
        add_vec(1, 4'h2, 32'h00008004, 32'h11111111, 8'h00, 32'h00000001);
        add_vec(1, 4'h0, 32'h00008004, 32'h0, 8'h00, 32'hAABB11DD);
        add_vec(0, 4'h0, 32'h0000F030, 32'h0, 8'h00, 32'hAABB11DD);
        add_vec(1, 4'hF, 32'h0000E000, 32'hFFFFFFFE, 8'h00, 32'hAABB11DD);
        add_vec(1, 4'h0, 32'h0000E000, 32'h0, 8'h00, 32'hFFFFFFFE);
        add_vec(0, 4'h0, 32'h0, 32'h0, 8'h00, 32'hFFFFFFFE);
        add_vec(0, 4'h0, 32'h0, 32'h0, 8'h00, 32'hFFFFFFFE);
        add_vec(0, 4'h0, 32'h0, 32'h0, 8'h00, 32'hFFFFFFFE);
        add_vec(1, 4'h0, 32'h0000E000, 32'h0, 8'h00, 32'h00000002);
        add_vec(1, 4'hF, 32'h0000FFF0, 32'h12345678, 8'h00, 32'h00000002);
        add_vec(1, 4'h0, 32'h0000FFF0, 32'h0, 8'h00, 32'h56781234);
        add_vec(1, 4'hF, 32'h0000F100, 32'hFFFFFFFF, 8'h00, 32'h56781234);
        add_vec(1, 4'h0, 32'h0000F100, 32'h0, 8'h00, 32'h00000000);
        add_vec(1, 4'h0, 32'h00008004, 32'h0, 8'h00, 32'hAABB11DD);
        add_vec(1, 4'h0, 32'h0000F020, 32'h0, 8'hA5, 32'h00000000);
        add_vec(0, 4'h0, 32'h0, 32'h0, 8'hA5, 32'h00000000);
        add_vec(0, 4'h0, 32'h0, 32'h0, 8'hA5, 32'h00000000);
        add_vec(1, 4'h0, 32'h0000F020, 32'h0, 8'hA5, 32'h000000A5);
        add_vec(1, 4'hF, 32'h0000F000, 32'hDEADBEEF, 8'hA5, 32'h000000A5);
        add_vec(1, 4'h0, 32'h0000F000, 32'h0, 8'hA5, 32'h0000BEEF);
        add_vec(1, 4'h1, 32'h0000F004, 32'hFFFFFFFF, 8'hA5, 32'h0000BEEF);
        add_vec(1, 4'h0, 32'h0000F004, 32'h0, 8'hA5, 32'h00000003);
        add_vec(1, 4'h0, 32'h00008006, 32'h0, 8'hA5, 32'hAABB11DD);
        add_vec(1, 4'h0, 32'h1FAF8004, 32'h0, 8'hA5, 32'hAABB11DD);
        add_vec(1, 4'h0, 32'h0000F030, 32'h0, 8'hA5, 32'h00000001);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].en, vq[i].wen, vq[i].addr, vq[i].wdata);
            switch = vq[i].sw;
            tick();
            chk($sformatf("vec%0d", i), rdata, vq[i].exp_rd);
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        chk("led_out", {16'h0, led}, 32'h0000BEEF);
        chk("rg0_out", {30'h0, led_rg0}, 32'h3);

        // Seven-segment scan with NUM = 0x3C.
        do_reset();
        drive(1'b1, 4'hF, 32'h0000F010, 32'h0000003C);
        tick();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        found = 1'b0;
        prev = num_csn;
        for (int n = 0; n < 80 && !found; n++) begin
            tick();
            if (prev == 8'h7F && num_csn == 8'hFE) found = 1'b1;
            prev = num_csn;
        end
        if (!found) begin
            errors++;
            $display("FAIL scan_wrap_wait: got no 7F->FE transition expected one within 80 cycles");
        end
        for (int i = 0; i < 32; i++) begin
            logic [7:0] ecsn;
            logic [6:0] eseg;
            if (i > 0) tick();
            ecsn = ~(8'd1 << (i / 4));
            eseg = (i / 4 == 0) ? 7'h4E : ((i / 4 == 1) ? 7'h79 : 7'h7E);
            chk($sformatf("scan_csn%0d", i), {24'h0, num_csn}, {24'h0, ecsn});
            chk($sformatf("scan_seg%0d", i), {25'h0, num_a_g}, {25'h0, eseg});
        end
        tick();
        chk("scan_wrap_csn", {24'h0, num_csn}, 32'hFE);
        chk("scan_wrap_seg", {25'h0, num_a_g}, 32'h4E);
        for (int i = 0; i < 4; i++) tick();
        chk("scan_mid_csn", {24'h0, num_csn}, 32'hFD);
        do_reset();

        // Random traffic against the model.
        model_on = 1'b1;
        for (int n = 0; n < 600; n++) begin
            logic [15:0] p = pool[$urandom_range(0, 17)];
            logic [3:0]  w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            drive($urandom_range(0, 9) != 0, w, {16'($urandom), p[15:2], 2'($urandom)}, $urandom);
            if ($urandom_range(0, 7) == 0) switch = 8'($urandom);
            if ($urandom_range(0, 99) == 0) do_reset();
            else tick();
        end
        model_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
